// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, sync/de decode with
// an optional pixel-qualified delay line, line/frame strobes, frame counter and blink.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0,
  parameter int unsigned PIPE      = 0,
  parameter int unsigned CW        = 10,
  parameter int unsigned BLINK_BIT = 5
) (
  input  logic          pixelClk,
  input  logic          reset,
  input  logic          pixEn,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          lineStart,
  output logic          frameStart,
  output logic [5:0]    frameCount,
  output logic          blink
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } decode_t;

  logic            hWrap;
  logic            vWrap;
  logic [CW-1:0]   hNext;
  logic [CW-1:0]   vNext;
  decode_t         nextDec;
  decode_t         outDec;
  logic [3*(PIPE+1)-1:0] pipeBits;
  logic [3*(PIPE+1)-1:0] pipeShift;

  // Decode the count value the registers will present after this edge, so that with
  // PIPE=0 the registered sync/de line up with the registered counters.
  always_comb begin
    hWrap = (hCount == H_LAST);
    vWrap = (vCount == V_LAST);
    hNext = hWrap ? '0 : hCount + CW'(1);
    vNext = vCount;
    if (hWrap) begin
      vNext = vWrap ? '0 : vCount + CW'(1);
    end
    nextDec.hs = (hNext >= HS_FIRST) && (hNext <= HS_LAST);
    nextDec.vs = (vNext >= VS_FIRST) && (vNext <= VS_LAST);
    nextDec.de = (hNext < H_VIS) && (vNext < V_VIS);
  end

  // Slot 0 holds the newest decode, slot PIPE the one presented on the outputs.
  if (PIPE == 0) begin : gNoPipe
    assign pipeShift = nextDec;
  end else begin : gPipe
    assign pipeShift = {pipeBits[3*PIPE-1:0], nextDec};
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      hCount     <= '0;
      vCount     <= '0;
      frameCount <= '0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      pipeBits   <= '0;
    end else begin
      lineStart  <= pixEn && hWrap;
      frameStart <= pixEn && hWrap && vWrap;
      if (pixEn) begin
        hCount   <= hNext;
        vCount   <= vNext;
        pipeBits <= pipeShift;
        if (hWrap && vWrap) begin
          frameCount <= frameCount + 6'd1;
        end
      end
    end
  end

  always_comb begin
    outDec = pipeBits[3*PIPE +: 3];
    hsync  = outDec.hs ? H_POL : ~H_POL;
    vsync  = outDec.vs ? V_POL : ~V_POL;
    de     = outDec.de;
    blink  = frameCount[BLINK_BIT];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an
// arithmetic model driven by the number of pixel steps since reset.
module tb_vga_timing_gen;

  typedef struct {
    longint hA, hF, hS, hB, vA, vF, vS, vB;
    bit     hPol, vPol;
    longint pipe;
    int     blinkBit;
  } cfg_t;

  typedef struct {
    longint h, v;
    bit     hs, vs, de, ls, fs, bl;
    longint fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic       rstA, enA, rstB, enB, rstC, enC;
  logic [3:0] hA, vA, hB, vB;
  logic [9:0] hC, vC;
  logic       hsA, vsA, deA, lsA, fsA, blA;
  logic       hsB, vsB, deB, lsB, fsB, blB;
  logic       hsC, vsC, deC, lsC, fsC, blC;
  logic [5:0] fcA, fcB, fcC;

  cfg_t   cfgA, cfgB, cfgC;
  longint nA, nB, nC;
  bit     stA, stB, stC;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .PIPE(0), .CW(4),
                   .BLINK_BIT(0)) dutA (
    .pixelClk(clk), .reset(rstA), .pixEn(enA), .hCount(hA), .vCount(vA), .hsync(hsA),
    .vsync(vsA), .de(deA), .lineStart(lsA), .frameStart(fsA), .frameCount(fcA), .blink(blA));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0), .PIPE(2), .CW(4),
                   .BLINK_BIT(5)) dutB (
    .pixelClk(clk), .reset(rstB), .pixEn(enB), .hCount(hB), .vCount(vB), .hsync(hsB),
    .vsync(vsB), .de(deB), .lineStart(lsB), .frameStart(fsB), .frameCount(fcB), .blink(blB));

  vga_timing_gen dutC (
    .pixelClk(clk), .reset(rstC), .pixEn(enC), .hCount(hC), .vCount(vC), .hsync(hsC),
    .vsync(vsC), .de(deC), .lineStart(lsC), .frameStart(fsC), .frameCount(fcC), .blink(blC));

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after n pixel steps since reset; stepped = last edge advanced.
  function automatic exp_t model(input cfg_t c, input longint n, input bit stepped);
    exp_t   e;
    longint ht, vt, m, ph, pv;
    bit     hsOn, vsOn, deOn;
    ht   = c.hA + c.hF + c.hS + c.hB;
    vt   = c.vA + c.vF + c.vS + c.vB;
    e.h  = n % ht;
    e.v  = (n / ht) % vt;
    e.fc = (n / (ht * vt)) % 64;
    e.bl = ((e.fc >> c.blinkBit) & 1) != 0;
    e.ls = stepped && (n >= 1) && (e.h == 0);
    e.fs = e.ls && (e.v == 0);
    m    = n - c.pipe;
    hsOn = 1'b0;
    vsOn = 1'b0;
    deOn = 1'b0;
    if (m >= 1) begin
      ph   = m % ht;
      pv   = (m / ht) % vt;
      hsOn = (ph >= c.hA + c.hF) && (ph < c.hA + c.hF + c.hS);
      vsOn = (pv >= c.vA + c.vF) && (pv < c.vA + c.vF + c.vS);
      deOn = (ph < c.hA) && (pv < c.vA);
    end
    e.hs = hsOn ? c.hPol : !c.hPol;
    e.vs = vsOn ? c.vPol : !c.vPol;
    e.de = deOn;
    return e;
  endfunction

  task automatic advance(inout longint n, inout bit st, input logic r, input logic en);
    if (r) begin
      n  = 0;
      st = 1'b0;
    end else if (en) begin
      n++;
      st = 1'b1;
    end else begin
      st = 1'b0;
    end
  endtask

  task automatic checkDut(input string nm, input cfg_t c, input longint n, input bit st,
                          input longint h, input longint v, input logic hs, input logic vs,
                          input logic d, input logic ls, input logic fs, input logic [5:0] fc,
                          input logic bl);
    exp_t e;
    e = model(c, n, st);
    checkVal({nm, "_hCount"}, h, e.h);
    checkVal({nm, "_vCount"}, v, e.v);
    checkVal({nm, "_hsync"}, hs, e.hs);
    checkVal({nm, "_vsync"}, vs, e.vs);
    checkVal({nm, "_de"}, d, e.de);
    checkVal({nm, "_lineStart"}, ls, e.ls);
    checkVal({nm, "_frameStart"}, fs, e.fs);
    checkVal({nm, "_frameCount"}, fc, e.fc);
    checkVal({nm, "_blink"}, bl, e.bl);
  endtask

  task automatic tick();
    @(posedge clk);
    advance(nA, stA, rstA, enA);
    advance(nB, stB, rstB, enB);
    advance(nC, stC, rstC, enC);
    @(negedge clk);
    checkDut("A", cfgA, nA, stA, longint'(hA), longint'(vA), hsA, vsA, deA, lsA, fsA, fcA, blA);
    checkDut("B", cfgB, nB, stB, longint'(hB), longint'(vB), hsB, vsB, deB, lsB, fsB, fcB, blB);
    checkDut("C", cfgC, nC, stC, longint'(hC), longint'(vC), hsC, vsC, deC, lsC, fsC, fcC, blC);
  endtask

  initial begin
    int  fsCnt, deCnt, fsClk, fsPrev, fall, fallPrev;
    bit  found, prevFs, prevBl, prevHs;

    cfgA = '{hA:8, hF:2, hS:3, hB:1, vA:4, vF:1, vS:2, vB:1, hPol:1'b0, vPol:1'b0, pipe:0, blinkBit:0};
    cfgB = '{hA:8, hF:2, hS:3, hB:1, vA:4, vF:1, vS:2, vB:1, hPol:1'b1, vPol:1'b0, pipe:2, blinkBit:5};
    cfgC = '{hA:640, hF:16, hS:96, hB:48, vA:480, vF:10, vS:2, vB:33, hPol:1'b0, vPol:1'b0,
             pipe:0, blinkBit:5};
    nA = 0; nB = 0; nC = 0; stA = 0; stB = 0; stC = 0;

    rstA = 1; rstB = 1; rstC = 1; enA = 0; enB = 0; enC = 0;
    tick();
    enA = 1; enB = 1; enC = 1;
    tick();

    // Full-speed frame from reset release.
    rstA = 0; rstB = 0; rstC = 0;
    fsCnt = 0; deCnt = 0; fsClk = -1;
    for (int k = 1; k <= 112; k++) begin
      tick();
      if (deA) deCnt++;
      if (fsA) begin
        fsCnt++;
        fsClk = k;
      end
    end
    checkVal("p1_fsCount", fsCnt, 1);
    checkVal("p1_fsClock", fsClk, 112);
    checkVal("p1_deCount", deCnt, 32);
    checkVal("p1_frameCount", fcA, 1);

    // pixEn 1-in-3 over two frames.
    rstA = 1; tick(); rstA = 0;
    fsCnt = 0; fsPrev = -1; prevFs = 0;
    for (int k = 0; k < 672; k++) begin
      enA = (k % 3 == 2);
      tick();
      if (prevFs) checkVal("p2_fsWidth", fsA, 0);
      if (fsA) begin
        fsCnt++;
        if (fsPrev >= 0) checkVal("p2_framePeriod", k - fsPrev, 336);
        fsPrev = k;
      end
      prevFs = fsA;
    end
    checkVal("p2_fsCount", fsCnt, 2);
    checkVal("p2_frameCount", fcA, 2);

    // Random pixEn and sporadic resets on all instances.
    for (int k = 0; k < 3000; k++) begin
      enA  = 1'($urandom_range(0, 1));
      enB  = 1'($urandom_range(0, 1));
      enC  = 1'($urandom_range(0, 1));
      rstA = ($urandom_range(0, 199) == 0);
      rstB = ($urandom_range(0, 199) == 0);
      rstC = ($urandom_range(0, 199) == 0);
      tick();
    end
    rstA = 0; rstB = 0; rstC = 0;

    // Mid-frame reset with vsync asserted and a full delay line.
    enA = 1; enB = 1; enC = 1;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (hB == 4'd9 && vB == 4'd6) found = 1;
    end
    checkVal("p4_reachedTarget", found, 1);
    checkVal("p4_vsyncBefore", vsB, 0);
    rstB = 1;
    tick();
    checkVal("p4_rst_hCount", hB, 0);
    checkVal("p4_rst_vCount", vB, 0);
    checkVal("p4_rst_hsync", hsB, 0);
    checkVal("p4_rst_vsync", vsB, 1);
    checkVal("p4_rst_de", deB, 0);
    rstB = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkVal("p4_noStaleDe", deB, 0);
      checkVal("p4_noStaleHs", hsB, 0);
    end

    // 64 frames on instance A: blink on bit 0 and frameCount wrap.
    rstA = 1; tick(); rstA = 0;
    fsCnt = 0; prevBl = blA;
    for (int k = 0; k < 64 * 112; k++) begin
      tick();
      if (fsA) begin
        fsCnt++;
        checkVal("p5_blinkToggle", blA, !prevBl);
        checkVal("p5_frameCount", fcA, fsCnt % 64);
      end
      prevBl = blA;
    end
    checkVal("p5_fsCount", fsCnt, 64);
    checkVal("p5_frameCountWrapped", fcA, 0);

    // Default 640x480 timing: hsync period.
    rstC = 1; tick(); rstC = 0;
    prevHs = hsC; fall = 0; fallPrev = -1;
    for (int k = 0; k < 2500; k++) begin
      tick();
      if (prevHs && !hsC) begin
        if (fallPrev >= 0) checkVal("p6_hsyncPeriod", k - fallPrev, 800);
        fallPrev = k;
        fall++;
      end
      prevHs = hsC;
    end
    checkVal("p6_hsyncFalls", fall, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
